// File: rtl/id_ex_stage.sv
// id_ex_stage
//   ID/EX pipeline register and operand-select stage for the 64-bit ALU.
//   It registers the decoded ID fields and the 4-bit ALU op code, forwards
//   from EX/MEM and MEM/WB, and drives the ALU operands and the EX control bits.
//   It supports stall (hold) and flush (bubble). Reset is asynchronous and
//   active-high, and clears every register.
//
// Ports
//   clk, reset            clock (rising edge), async active-high reset
//   stall, flush          hold EX contents / insert bubble (flush overrides stall)
//   id_*                  decoded instruction fields and control bits from ID
//   exmem_*, memwb_*      write-back destinations and values for forwarding
//   ex_a, ex_b            ALU operands (forwarded rs1; imm or forwarded rs2)
//   ex_alu_op             0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1111 unsupported
//   ex_store_data         forwarded rs2
//   ex_pc, ex_imm, ex_rd, ex_rs1, ex_rs2, ex_valid, ex_<ctrl>  registered fields
module id_ex_stage #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned REGW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic [REGW-1:0] id_rd,
  input  logic [1:0]      id_alu_op,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7_b5,
  input  logic            id_alu_src,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_mem_to_reg,
  input  logic            id_branch,
  input  logic            exmem_reg_write,
  input  logic [REGW-1:0] exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_reg_write,
  input  logic [REGW-1:0] memwb_rd,
  input  logic [XLEN-1:0] memwb_result,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [3:0]      ex_alu_op,
  output logic [XLEN-1:0] ex_store_data,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm,
  output logic [REGW-1:0] ex_rd,
  output logic [REGW-1:0] ex_rs1,
  output logic [REGW-1:0] ex_rs2,
  output logic            ex_valid,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_mem_to_reg,
  output logic            ex_branch
);

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_BAD = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    CLS_MEM    = 2'b00,
    CLS_BRANCH = 2'b01,
    CLS_RTYPE  = 2'b10,
    CLS_ITYPE  = 2'b11
  } alu_cls_e;

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic            branch;
    logic            alu_src;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [REGW-1:0] rd;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
  } ex_t;

  ex_t             ex_q, ex_d;
  alu_op_e         alu_op_dec;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  // ALU op decode from main-control class and funct bits
  always_comb begin
    alu_op_dec = ALU_BAD;
    case (alu_cls_e'(id_alu_op))
      CLS_MEM:    alu_op_dec = ALU_ADD;
      CLS_BRANCH: alu_op_dec = ALU_SUB;
      default: begin
        case (id_funct3)
          // bit 30 selects SUB only for R-type; for I-type it is immediate data
          3'b000:  alu_op_dec = (alu_cls_e'(id_alu_op) == CLS_RTYPE && id_funct7_b5)
                                ? ALU_SUB : ALU_ADD;
          3'b111:  alu_op_dec = ALU_AND;
          3'b110:  alu_op_dec = ALU_OR;
          default: alu_op_dec = ALU_BAD;
        endcase
      end
    endcase
  end

  // Forwarding: EX/MEM beats MEM/WB, x0 never forwards
  always_comb begin
    fwd_rs1 = ex_q.rs1_data;
    if (exmem_reg_write && exmem_rd != '0 && exmem_rd == ex_q.rs1)
      fwd_rs1 = exmem_result;
    else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == ex_q.rs1)
      fwd_rs1 = memwb_result;

    fwd_rs2 = ex_q.rs2_data;
    if (exmem_reg_write && exmem_rd != '0 && exmem_rd == ex_q.rs2)
      fwd_rs2 = exmem_result;
    else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == ex_q.rs2)
      fwd_rs2 = memwb_result;
  end

  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (stall) begin
      // Latch forwarded operands while held, so producers retiring during
      // the stall are not lost (non-forwarding case rewrites the same value)
      ex_d.rs1_data = fwd_rs1;
      ex_d.rs2_data = fwd_rs2;
    end else if (!id_valid) begin
      ex_d = '0;
    end else begin
      ex_d.valid      = 1'b1;
      ex_d.reg_write  = id_reg_write;
      ex_d.mem_read   = id_mem_read;
      ex_d.mem_write  = id_mem_write;
      ex_d.mem_to_reg = id_mem_to_reg;
      ex_d.branch     = id_branch;
      ex_d.alu_src    = id_alu_src;
      ex_d.alu_op     = alu_op_dec;
      ex_d.pc         = id_pc;
      ex_d.imm        = id_imm;
      ex_d.rs1_data   = id_rs1_data;
      ex_d.rs2_data   = id_rs2_data;
      ex_d.rd         = id_rd;
      ex_d.rs1        = id_rs1;
      ex_d.rs2        = id_rs2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  assign ex_a          = fwd_rs1;
  assign ex_b          = ex_q.alu_src ? ex_q.imm : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign ex_alu_op     = ex_q.alu_op;
  assign ex_pc         = ex_q.pc;
  assign ex_imm        = ex_q.imm;
  assign ex_rd         = ex_q.rd;
  assign ex_rs1        = ex_q.rs1;
  assign ex_rs2        = ex_q.rs2;
  assign ex_valid      = ex_q.valid;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_branch     = ex_q.branch;

endmodule
